// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding and hazard controller:
// default register index width and the bypass source select encodings.
package fwd_hazard_ctrl_pkg;

    localparam int RW_DEFAULT = 5;

    localparam logic [1:0] FSEL_NONE  = 2'b00;
    localparam logic [1:0] FSEL_EXMEM = 2'b01;
    localparam logic [1:0] FSEL_MEMWB = 2'b10;
    localparam logic [1:0] FSEL_WB    = 2'b11;

endpackage

// File: rtl/fwd_hazard_ctrl_match.sv
// Per-operand comparator: checks one ID source index against the three
// in-flight write slots (EX, MEM, WB) and picks the newest producer.
// Also flags when the newest producer is a load still sitting in EX,
// which is the only case that cannot be bypassed in time.
module fwd_match
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int RW      = RW_DEFAULT,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic          ex_valid,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_load,
    input  logic          mem_valid,
    input  logic [RW-1:0] mem_rd,
    input  logic          wb_valid,
    input  logic [RW-1:0] wb_rd,
    input  logic [RW-1:0] src,
    input  logic          use_src,
    output logic          forward,
    output logic [1:0]    fsel,
    output logic          ex_load_hit
);

    logic src_ok;
    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    assign src_ok  = use_src & !(R0_ZERO && (src == '0));
    assign hit_ex  = src_ok & ex_valid  & (ex_rd  == src);
    assign hit_mem = src_ok & mem_valid & (mem_rd == src);
    assign hit_wb  = src_ok & wb_valid  & (wb_rd  == src);

    // Newest producer wins: EX over MEM over WB
    always_comb begin
        forward     = 1'b0;
        fsel        = FSEL_NONE;
        ex_load_hit = hit_ex & ex_load;
        if (hit_ex) begin
            forward = 1'b1;
            fsel    = FSEL_EXMEM;
        end else if (hit_mem) begin
            forward = 1'b1;
            fsel    = FSEL_MEMWB;
        end else if (hit_wb) begin
            forward = 1'b1;
            fsel    = FSEL_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the EX operand muxes.
// Tracks in-flight register writes in a 3-slot scoreboard (EX, MEM, WB),
// registers per-operand bypass selects for EX and raises a one-cycle
// combinational stall on a load-use dependency.
// Optional build macro FWD_HAZARD_STATS_EN adds saturating counters for
// stall cycles and forwarding EX cycles.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int RW      = RW_DEFAULT,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [RW-1:0] id_ra,
    input  logic [RW-1:0] id_rb,
    input  logic          id_use_ra,
    input  logic          id_use_rb,
    input  logic          id_use_imm,
    input  logic [RW-1:0] id_rd,
    input  logic          id_we,
    input  logic          id_load,
    input  logic          flush,
    output logic          forward_a,
    output logic          forward_b,
    output logic [1:0]    fsel_a,
    output logic [1:0]    fsel_b,
`ifdef FWD_HAZARD_STATS_EN
    output logic [15:0]   stat_stalls,
    output logic [15:0]   stat_fwds,
`endif
    output logic          stall
);

    // Only the EX slot keeps the load flag: once a load reaches MEM its
    // data is ready at the end of that stage and forwards normally.
    logic          ex_valid;
    logic [RW-1:0] ex_rd;
    logic          ex_load;
    logic          mem_valid;
    logic [RW-1:0] mem_rd;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;

    logic          fwd_a_c;
    logic          fwd_b_c;
    logic [1:0]    fsel_a_c;
    logic [1:0]    fsel_b_c;
    logic          load_hit_a;
    logic          load_hit_b;
    logic          issue;
    logic          entry_valid;
    logic          use_b_bypass;

    fwd_match #(.RW(RW), .R0_ZERO(R0_ZERO)) u_match_a (
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_load     (ex_load),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .src         (id_ra),
        .use_src     (id_use_ra),
        .forward     (fwd_a_c),
        .fsel        (fsel_a_c),
        .ex_load_hit (load_hit_a)
    );

    fwd_match #(.RW(RW), .R0_ZERO(R0_ZERO)) u_match_b (
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_load     (ex_load),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .src         (id_rb),
        .use_src     (id_use_rb),
        .forward     (fwd_b_c),
        .fsel        (fsel_b_c),
        .ex_load_hit (load_hit_b)
    );

    // A flushed or empty ID slot issues nothing into EX; register 0 never
    // becomes a tracked destination when it is hardwired to zero.
    assign issue        = id_valid & ~flush;
    assign entry_valid  = issue & id_we & !(R0_ZERO && (id_rd == '0));
    assign use_b_bypass = issue & ~id_use_imm;

    // Load-use hazard: the value arrives too late for EX, hold ID one cycle
    assign stall = issue & (load_hit_a | load_hit_b);

    // Scoreboard shift and registered EX bypass selects; a stall injects a bubble
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_rd     <= '0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_rd    <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            forward_a <= 1'b0;
            forward_b <= 1'b0;
            fsel_a    <= FSEL_NONE;
            fsel_b    <= FSEL_NONE;
        end else begin
            wb_valid  <= mem_valid;
            wb_rd     <= mem_rd;
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            if (stall) begin
                ex_valid  <= 1'b0;
                ex_rd     <= '0;
                ex_load   <= 1'b0;
                forward_a <= 1'b0;
                forward_b <= 1'b0;
                fsel_a    <= FSEL_NONE;
                fsel_b    <= FSEL_NONE;
            end else begin
                ex_valid  <= entry_valid;
                ex_rd     <= id_rd;
                ex_load   <= id_load;
                forward_a <= issue & fwd_a_c;
                fsel_a    <= issue ? fsel_a_c : FSEL_NONE;
                forward_b <= use_b_bypass & fwd_b_c;
                fsel_b    <= use_b_bypass ? fsel_b_c : FSEL_NONE;
            end
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    // Saturating event counters for stall cycles and forwarding EX cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_stalls <= '0;
            stat_fwds   <= '0;
        end else begin
            if (stall && (stat_stalls != 16'hFFFF)) begin
                stat_stalls <= stat_stalls + 16'd1;
            end
            if ((forward_a | forward_b) && (stat_fwds != 16'hFFFF)) begin
                stat_fwds <= stat_fwds + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed instruction sequences
// against a distance-based pipeline model, plus literal expectations.
module tb_fwd_hazard_ctrl;
    import fwd_hazard_ctrl_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_ra;
    logic [4:0] id_rb;
    logic       id_use_ra;
    logic       id_use_rb;
    logic       id_use_imm;
    logic [4:0] id_rd;
    logic       id_we;
    logic       id_load;
    logic       flush;
    logic       forward_a;
    logic       forward_b;
    logic [1:0] fsel_a;
    logic [1:0] fsel_b;
    logic       stall;
`ifdef FWD_HAZARD_STATS_EN
    logic [15:0] stat_stalls;
    logic [15:0] stat_fwds;
`endif

    fwd_hazard_ctrl #(.RW(5), .R0_ZERO(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_ra      (id_ra),
        .id_rb      (id_rb),
        .id_use_ra  (id_use_ra),
        .id_use_rb  (id_use_rb),
        .id_use_imm (id_use_imm),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_load    (id_load),
        .flush      (flush),
        .forward_a  (forward_a),
        .forward_b  (forward_b),
        .fsel_a     (fsel_a),
        .fsel_b     (fsel_b),
`ifdef FWD_HAZARD_STATS_EN
        .stat_stalls(stat_stalls),
        .stat_fwds  (stat_fwds),
`endif
        .stall      (stall)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model: list of instructions that entered EX, index 0 = most recent,
    // index d means the producer is d+1 stages ahead of the reader.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } ent_t;

    ent_t       pipe [3];
    logic       m_fa;
    logic       m_fb;
    logic [1:0] m_fsa;
    logic [1:0] m_fsb;
    int         m_stalls;
    int         m_fwds;
    bit         armed = 1'b0;
    logic       last_stall;

    // Distance to the newest writer of src, encoded as the bypass select
    function automatic logic [1:0] m_src(input logic [4:0] src, input logic use_it);
        if (!use_it || src == 5'd0) return 2'b00;
        for (int d = 0; d < 3; d++) begin
            if (pipe[d].v && pipe[d].rd == src) return 2'(d + 1);
        end
        return 2'b00;
    endfunction

    function automatic logic m_stall();
        return id_valid && !flush && pipe[0].v && pipe[0].ld &&
               (m_src(id_ra, id_use_ra) == 2'd1 || m_src(id_rb, id_use_rb) == 2'd1);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic modelEdge();
        logic       st;
        logic       iss;
        logic [1:0] sa;
        logic [1:0] sb;
        if (reset) begin
            for (int d = 0; d < 3; d++) pipe[d] = '0;
            m_fa = 0; m_fb = 0; m_fsa = 0; m_fsb = 0;
            m_stalls = 0; m_fwds = 0;
        end else begin
            st = m_stall();
            if ((m_fa || m_fb) && m_fwds < 65535) m_fwds++;
            if (st && m_stalls < 65535) m_stalls++;
            if (st) begin
                pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = '0;
                m_fa = 0; m_fb = 0; m_fsa = 0; m_fsb = 0;
            end else begin
                iss = id_valid && !flush;
                sa = m_src(id_ra, id_use_ra);
                sb = id_use_imm ? 2'b00 : m_src(id_rb, id_use_rb);
                m_fsa = iss ? sa : 2'b00;
                m_fsb = iss ? sb : 2'b00;
                m_fa = (m_fsa != 2'b00);
                m_fb = (m_fsb != 2'b00);
                pipe[2] = pipe[1]; pipe[1] = pipe[0];
                pipe[0].v  = iss && id_we && id_rd != 5'd0;
                pipe[0].rd = id_rd;
                pipe[0].ld = id_load;
            end
        end
    endtask

    // Drive one ID cycle, check the comb stall mid-cycle, then the registered outputs after the edge
    task automatic applyStimulus(input logic v, input logic [4:0] ra, input logic ura,
                                 input logic [4:0] rb, input logic urb, input logic imm,
                                 input logic [4:0] rd, input logic we, input logic ld,
                                 input logic fl, input logic rst);
        @(negedge clock);
        id_valid = v; id_ra = ra; id_use_ra = ura; id_rb = rb; id_use_rb = urb;
        id_use_imm = imm; id_rd = rd; id_we = we; id_load = ld; flush = fl; reset = rst;
        #1;
        last_stall = stall;
        if (armed) checkOutput("stall", 16'(stall), 16'(m_stall()));
        @(posedge clock);
        modelEdge();
        if (rst) armed = 1'b1;
        #1;
        if (armed) begin
            checkOutput("forward_a", 16'(forward_a), 16'(m_fa));
            checkOutput("forward_b", 16'(forward_b), 16'(m_fb));
            checkOutput("fsel_a", 16'(fsel_a), 16'(m_fsa));
            checkOutput("fsel_b", 16'(fsel_b), 16'(m_fsb));
`ifdef FWD_HAZARD_STATS_EN
            checkOutput("stat_stalls", stat_stalls, 16'(m_stalls));
            checkOutput("stat_fwds", stat_fwds, 16'(m_fwds));
`endif
        end
    endtask

    task automatic nop();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic writeReg(input logic [4:0] rd, input logic ld);
        applyStimulus(1, 0, 0, 0, 0, 0, rd, 1, ld, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) nop();
    endtask

    initial begin
        reset = 1; id_valid = 0; id_ra = 0; id_rb = 0; id_use_ra = 0; id_use_rb = 0;
        id_use_imm = 0; id_rd = 0; id_we = 0; id_load = 0; flush = 0;
        for (int d = 0; d < 3; d++) pipe[d] = '0;
        m_fa = 0; m_fb = 0; m_fsa = 0; m_fsb = 0; m_stalls = 0; m_fwds = 0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("reset_forward_a", 16'(forward_a), 16'd0);
        checkOutput("reset_fsel_b", 16'(fsel_b), 16'd0);
        checkOutput("reset_stall", 16'(last_stall), 16'd0);

        // EX-to-EX forward on A
        writeReg(5'd3, 0);
        applyStimulus(1, 5'd3, 1, 0, 0, 0, 5'd6, 1, 0, 0, 0);
        checkOutput("t1_forward_a", 16'(forward_a), 16'd1);
        checkOutput("t1_fsel_a", 16'(fsel_a), 16'(FSEL_EXMEM));
        checkOutput("t1_stall", 16'(last_stall), 16'd0);
        drain();

        // Load-use on B: one stall, bubble, then MEM forward
        writeReg(5'd5, 1);
        applyStimulus(1, 0, 0, 5'd5, 1, 0, 5'd7, 1, 0, 0, 0);
        checkOutput("t2_stall", 16'(last_stall), 16'd1);
        checkOutput("t2_bubble_fb", 16'(forward_b), 16'd0);
        applyStimulus(1, 0, 0, 5'd5, 1, 0, 5'd7, 1, 0, 0, 0);
        checkOutput("t2_stall_once", 16'(last_stall), 16'd0);
        checkOutput("t2_forward_b", 16'(forward_b), 16'd1);
        checkOutput("t2_fsel_b", 16'(fsel_b), 16'(FSEL_MEMWB));
        drain();

        // Same rd in EX and MEM: newest wins; immediate B never forwarded
        writeReg(5'd4, 0);
        writeReg(5'd4, 0);
        applyStimulus(1, 5'd4, 1, 5'd4, 1, 1, 5'd8, 1, 0, 0, 0);
        checkOutput("t3_fsel_a", 16'(fsel_a), 16'(FSEL_EXMEM));
        checkOutput("t3_imm_fb", 16'(forward_b), 16'd0);
        applyStimulus(1, 0, 0, 5'd4, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_fsel_b_mem", 16'(fsel_b), 16'(FSEL_MEMWB));
        drain();

        // WB-distance forward
        writeReg(5'd9, 0);
        nop();
        nop();
        applyStimulus(1, 5'd9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_fsel_a_wb", 16'(fsel_a), 16'(FSEL_WB));
        drain();

        // r0 never forwards; id_we=0 never matches
        writeReg(5'd0, 0);
        applyStimulus(1, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_r0_fa", 16'(forward_a), 16'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 5'd11, 0, 0, 0, 0);
        applyStimulus(1, 5'd11, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_nowe_fa", 16'(forward_a), 16'd0);
        drain();

        // Flush beats load-use stall
        writeReg(5'd5, 1);
        applyStimulus(1, 0, 0, 5'd5, 1, 0, 5'd7, 1, 0, 1, 0);
        checkOutput("t4_flush_stall", 16'(last_stall), 16'd0);
        checkOutput("t4_flush_fb", 16'(forward_b), 16'd0);
        applyStimulus(1, 0, 0, 5'd5, 1, 0, 5'd7, 1, 0, 0, 0);
        checkOutput("t4_after_flush_fsel_b", 16'(fsel_b), 16'(FSEL_MEMWB));
        drain();

        // Reset during a stall clears everything
        writeReg(5'd5, 1);
        applyStimulus(1, 0, 0, 5'd5, 1, 0, 5'd7, 1, 0, 0, 1);
        checkOutput("t5_stall_at_reset", 16'(last_stall), 16'd1);
        checkOutput("t5_reset_fb", 16'(forward_b), 16'd0);
        applyStimulus(1, 0, 0, 5'd5, 1, 0, 5'd7, 1, 0, 0, 0);
        checkOutput("t5_no_stall", 16'(last_stall), 16'd0);
        checkOutput("t5_empty_fb", 16'(forward_b), 16'd0);
        drain();

        // Three load-use pairs
        for (int k = 0; k < 3; k++) begin
            writeReg(5'(12 + k), 1);
            applyStimulus(1, 5'(12 + k), 1, 0, 0, 0, 5'd20, 1, 0, 0, 0);
            applyStimulus(1, 5'(12 + k), 1, 0, 0, 0, 5'd20, 1, 0, 0, 0);
            checkOutput("t5_pair_fsel_a", 16'(fsel_a), 16'(FSEL_MEMWB));
            drain();
        end
`ifdef FWD_HAZARD_STATS_EN
        checkOutput("t5_stat_stalls", stat_stalls, 16'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
